// File: rtl/div_sequencer.sv
// Run controller for the measurement counter's programmable clock divider.
// Optional burst mode is compiled in when DIVSEQ_BURST_EN is defined.
module div_sequencer #(
  parameter int unsigned LOGLENGTH    = 31,
  parameter int unsigned DEFAULT_HALF = 50000,
  parameter int unsigned BURSTW       = 16
) (
  input  logic                 inclk,
  input  logic                 reset_n,
  input  logic                 cfg_valid,
  input  logic [LOGLENGTH:0]   cfg_half,
  output logic                 cfg_ready,
  input  logic                 start,
  input  logic                 stop,
  input  logic [BURSTW-1:0]    burst_len,
  output logic                 newclk,
  output logic                 tick,
  output logic                 busy,
  output logic                 done,
  output logic [LOGLENGTH:0]   cur_half
);

  localparam int unsigned W = LOGLENGTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   pend_half_q, pend_half_d;
  logic [W-1:0]   cur_half_d;
  logic [W-1:0]   cfg_clamp_c;
  logic           newclk_d, tick_d, busy_d, done_d, cfg_ready_d;
  logic           boundary_c, rise_c, launch_c, burst_end_c;

  assign cfg_clamp_c = (cfg_half == '0) ? W'(1) : cfg_half;
  assign boundary_c  = (state_q != IDLE) && (count_q == W'(cur_half - W'(1)));
  assign rise_c      = boundary_c && !newclk;
  assign launch_c    = (state_q == IDLE) && start && !stop;

`ifdef DIVSEQ_BURST_EN
  logic [BURSTW-1:0] burst_cnt_q, burst_cnt_d;
  logic [BURSTW-1:0] burst_tgt_q, burst_tgt_d;

  // Burst target latched at launch; count advances on each rising boundary
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    burst_tgt_d = burst_tgt_q;
    if (launch_c) begin
      burst_cnt_d = '0;
      burst_tgt_d = burst_len;
    end else if ((state_q == RUN) && !stop && rise_c) begin
      burst_cnt_d = BURSTW'(burst_cnt_q + BURSTW'(1));
    end
  end

  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt_q <= '0;
      burst_tgt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      burst_tgt_q <= burst_tgt_d;
    end
  end

  assign burst_end_c = (burst_tgt_q != '0) &&
                       (BURSTW'(burst_cnt_q + BURSTW'(1)) == burst_tgt_q);
`else
  logic unused_burst_len;
  assign unused_burst_len = ^burst_len;
  assign burst_end_c      = 1'b0;
`endif

  // Next-state, divider and config pipeline
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pend_half_d = pend_half_q;
    cur_half_d  = cur_half;
    newclk_d    = newclk;
    tick_d      = 1'b0;
    busy_d      = busy;
    done_d      = 1'b0;
    cfg_ready_d = cfg_ready;

    if (state_q == IDLE) begin
      // A config left pending by an early stop lands as soon as we idle
      if (!cfg_ready) begin
        cur_half_d  = pend_half_q;
        cfg_ready_d = 1'b1;
      end else if (cfg_valid) begin
        cur_half_d = cfg_clamp_c;
      end
    end else begin
      if (boundary_c && !cfg_ready) begin
        cur_half_d  = pend_half_q;
        cfg_ready_d = 1'b1;
      end else if (cfg_valid && cfg_ready) begin
        pend_half_d = cfg_clamp_c;
        cfg_ready_d = 1'b0;
      end
      if (boundary_c) begin
        count_d  = '0;
        newclk_d = !newclk;
      end else begin
        count_d = W'(count_q + W'(1));
      end
    end

    case (state_q)
      IDLE: begin
        if (launch_c) begin
          state_d = RUN;
          busy_d  = 1'b1;
          count_d = '0;
        end
      end
      RUN: begin
        // A falling boundary coincident with stop finishes the drain at once
        if (stop) begin
          if (!newclk || boundary_c) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            newclk_d = 1'b0;
          end else begin
            state_d = DRAIN;
          end
        end else if (rise_c) begin
          tick_d = 1'b1;
          if (burst_end_c) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (boundary_c) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          newclk_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        newclk_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      pend_half_q <= '0;
      cur_half    <= W'(DEFAULT_HALF);
      newclk      <= 1'b0;
      tick        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_ready   <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pend_half_q <= pend_half_d;
      cur_half    <= cur_half_d;
      newclk      <= newclk_d;
      tick        <= tick_d;
      busy        <= busy_d;
      done        <= done_d;
      cfg_ready   <= cfg_ready_d;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: randomized runs against a
// boundary-schedule reference model.
module tb_div_sequencer;

  localparam int unsigned LOGLENGTH    = 31;
  localparam int unsigned DEFAULT_HALF = 4;
  localparam int unsigned BURSTW       = 16;

  logic                inclk = 1'b0;
  logic                reset_n;
  logic                cfg_valid;
  logic [LOGLENGTH:0]  cfg_half;
  logic                cfg_ready;
  logic                start;
  logic                stop;
  logic [BURSTW-1:0]   burst_len;
  logic                newclk;
  logic                tick;
  logic                busy;
  logic                done;
  logic [LOGLENGTH:0]  cur_half;

  int checks = 0;
  int errors = 0;

  div_sequencer #(
    .LOGLENGTH   (LOGLENGTH),
    .DEFAULT_HALF(DEFAULT_HALF),
    .BURSTW      (BURSTW)
  ) dut (
    .inclk    (inclk),
    .reset_n  (reset_n),
    .cfg_valid(cfg_valid),
    .cfg_half (cfg_half),
    .cfg_ready(cfg_ready),
    .start    (start),
    .stop     (stop),
    .burst_len(burst_len),
    .newclk   (newclk),
    .tick     (tick),
    .busy     (busy),
    .done     (done),
    .cur_half (cur_half)
  );

  always #5 inclk = ~inclk;

  task automatic step();
    @(posedge inclk);
    #1;
  endtask

  // newclk k cycles after launch with a constant half-period h
  function automatic logic exp_nc(int k, int h);
    return ((k / h) % 2) == 1;
  endfunction

  // Expected {busy,newclk,tick,done} while running at constant h
  function automatic logic [3:0] exp_run(int k, int h);
    logic n, t;
    n = exp_nc(k, h);
    t = (k > 0) && n && !exp_nc(k - 1, h);
    return {1'b1, n, t, 1'b0};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
    start = 1'b0; stop = 1'b0; burst_len = '0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    checks++;
    if ({busy, newclk, tick, done} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs got %b exp 0000", {busy, newclk, tick, done});
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cfg_ready got %b exp 1", cfg_ready);
    end
    checks++;
    if (cur_half !== 32'(DEFAULT_HALF)) begin
      errors++; $display("FAIL reset_cur_half got %0d exp %0d", cur_half, DEFAULT_HALF);
    end
  endtask

  task automatic test_free_run();
    for (int trial = 0; trial < 3; trial++) begin
      int h, run, k;
      h = (trial == 0) ? 4 : int'($urandom_range(1, 6));
      if (trial != 0) begin
        cfg_valid = 1'b1; cfg_half = 32'(h);
        step();
        cfg_valid = 1'b0;
      end
      checks++;
      if (cur_half !== 32'(h) || cfg_ready !== 1'b1) begin
        errors++; $display("FAIL free_cfg cur_half %0d rdy %b exp %0d rdy 1", cur_half, cfg_ready, h);
      end
      start = 1'b1; burst_len = '0;
      step();
      start = 1'b0;
      checks++;
      if ({busy, newclk, tick, done} !== exp_run(0, h)) begin
        errors++; $display("FAIL free_launch got %b exp %b", {busy, newclk, tick, done}, exp_run(0, h));
      end
      run = int'($urandom_range(2 * h, 4 * h));
      k = 0;
      while (k < run || exp_nc(k, h)) begin
        step(); k++;
        checks++;
        if ({busy, newclk, tick, done} !== exp_run(k, h)) begin
          errors++;
          $display("FAIL free_run h=%0d k=%0d got %b exp %b", h, k, {busy, newclk, tick, done}, exp_run(k, h));
        end
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      checks++;
      if ({busy, newclk, tick, done} !== 4'b0001) begin
        errors++; $display("FAIL free_stop got %b exp 0001", {busy, newclk, tick, done});
      end
      step();
      checks++;
      if ({busy, newclk, tick, done} !== 4'b0000) begin
        errors++; $display("FAIL free_idle got %b exp 0000", {busy, newclk, tick, done});
      end
    end
  endtask

  task automatic test_cfg_in_run();
    for (int trial = 0; trial < 4; trial++) begin
      int h0, h1, a, k, next_b, hc, half;
      logic nc, tk, pend, rdy;
      h0 = (trial == 0) ? 4 : int'($urandom_range(2, 6));
      h1 = (trial == 0) ? 2 : int'($urandom_range(1, 6));
      a  = (trial == 0) ? 6 : int'($urandom_range(1, 2 * h0));
      cfg_valid = 1'b1; cfg_half = 32'(h0);
      step();
      cfg_valid = 1'b0;
      start = 1'b1; burst_len = '0;
      step();
      start = 1'b0;
      nc = 1'b0; next_b = h0; hc = h0; half = h0; pend = 1'b0; rdy = 1'b1; k = 0;
      while (!(k >= a + 2 * h0 + 2 * h1 && !nc) && k < 200) begin
        if (k + 1 == a) begin cfg_valid = 1'b1; cfg_half = 32'(h1); end
        step(); k++;
        cfg_valid = 1'b0;
        tk = 1'b0;
        if (k == next_b) begin
          nc = !nc; tk = nc;
          if (pend) begin hc = h1; half = h1; pend = 1'b0; rdy = 1'b1; end
          next_b = k + hc;
        end
        if (k == a) begin pend = 1'b1; rdy = 1'b0; end
        checks++;
        if ({busy, newclk, tick, done, cfg_ready} !== {1'b1, nc, tk, 1'b0, rdy} || cur_half !== 32'(half)) begin
          errors++;
          $display("FAIL cfg_run h0=%0d h1=%0d a=%0d k=%0d got %b half %0d exp %b half %0d",
                   h0, h1, a, k, {busy, newclk, tick, done, cfg_ready}, cur_half,
                   {1'b1, nc, tk, 1'b0, rdy}, half);
        end
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      checks++;
      if ({busy, newclk, tick, done} !== 4'b0001 || cur_half !== 32'(h1)) begin
        errors++; $display("FAIL cfg_stop got %b half %0d exp 0001 half %0d", {busy, newclk, tick, done}, cur_half, h1);
      end
      step();
    end
  endtask

  task automatic test_stop_drain();
    for (int trial = 0; trial < 3; trial++) begin
      int h, ks;
      logic [3:0] e;
      h = int'($urandom_range(2, 5));
      ks = (trial == 0) ? 2 * h : (trial == 1) ? h + 1 : int'($urandom_range(h + 1, 2 * h));
      cfg_valid = 1'b1; cfg_half = 32'(h);
      step();
      cfg_valid = 1'b0;
      start = 1'b1; burst_len = '0;
      step();
      start = 1'b0;
      for (int k = 1; k < ks; k++) begin
        step();
        checks++;
        if ({busy, newclk, tick, done} !== exp_run(k, h)) begin
          errors++; $display("FAIL drain_pre h=%0d k=%0d got %b exp %b", h, k, {busy, newclk, tick, done}, exp_run(k, h));
        end
      end
      // start held with stop: ignored while running and while idle
      stop = 1'b1; start = 1'b1;
      for (int k = ks; k <= 2 * h; k++) begin
        step();
        e = (k < 2 * h) ? 4'b1100 : 4'b0001;
        checks++;
        if ({busy, newclk, tick, done} !== e) begin
          errors++; $display("FAIL drain h=%0d ks=%0d k=%0d got %b exp %b", h, ks, k, {busy, newclk, tick, done}, e);
        end
      end
      step();
      stop = 1'b0; start = 1'b0;
      checks++;
      if ({busy, newclk, tick, done} !== 4'b0000) begin
        errors++; $display("FAIL drain_after got %b exp 0000", {busy, newclk, tick, done});
      end
    end
  endtask

  task automatic test_idle_controls();
    start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({busy, newclk, tick, done} !== 4'b0000) begin
        errors++; $display("FAIL idle_start_stop i=%0d got %b exp 0000", i, {busy, newclk, tick, done});
      end
    end
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({busy, newclk, tick, done} !== 4'b0000) begin
        errors++; $display("FAIL idle_stop i=%0d got %b exp 0000", i, {busy, newclk, tick, done});
      end
    end
    stop = 1'b0;
  endtask

  task automatic test_cfg_zero();
    int k;
    cfg_valid = 1'b1; cfg_half = '0;
    step();
    cfg_valid = 1'b0;
    checks++;
    if (cur_half !== 32'd1) begin
      errors++; $display("FAIL cfg_zero_clamp got %0d exp 1", cur_half);
    end
    start = 1'b1; burst_len = '0;
    step();
    start = 1'b0;
    k = 0;
    while (k < 8 || exp_nc(k, 1)) begin
      step(); k++;
      checks++;
      if ({busy, newclk, tick, done} !== exp_run(k, 1)) begin
        errors++; $display("FAIL cfg_zero_run k=%0d got %b exp %b", k, {busy, newclk, tick, done}, exp_run(k, 1));
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if ({busy, newclk, tick, done} !== 4'b0001) begin
      errors++; $display("FAIL cfg_zero_stop got %b exp 0001", {busy, newclk, tick, done});
    end
    step();
  endtask

`ifdef DIVSEQ_BURST_EN
  task automatic test_burst();
    for (int trial = 0; trial < 4; trial++) begin
      int h, n, ticks;
      logic [3:0] e;
      h = (trial == 0) ? 4 : int'($urandom_range(1, 5));
      n = (trial == 0) ? 3 : int'($urandom_range(1, 4));
      cfg_valid = 1'b1; cfg_half = 32'(h);
      step();
      cfg_valid = 1'b0;
      start = 1'b1; burst_len = BURSTW'(n);
      step();
      start = 1'b0; burst_len = BURSTW'($urandom);
      ticks = 0;
      for (int k = 1; k <= 2 * n * h; k++) begin
        step();
        if (tick === 1'b1) ticks++;
        e = (k < 2 * n * h) ? exp_run(k, h) : 4'b0001;
        checks++;
        if ({busy, newclk, tick, done} !== e) begin
          errors++; $display("FAIL burst h=%0d n=%0d k=%0d got %b exp %b", h, n, k, {busy, newclk, tick, done}, e);
        end
      end
      checks++;
      if (ticks != n) begin
        errors++; $display("FAIL burst_ticks got %0d exp %0d", ticks, n);
      end
      step();
      checks++;
      if ({busy, newclk, tick, done} !== 4'b0000) begin
        errors++; $display("FAIL burst_after got %b exp 0000", {busy, newclk, tick, done});
      end
      burst_len = '0;
    end
  endtask
`else
  task automatic test_burst();
    int k;
    cfg_valid = 1'b1; cfg_half = 32'd2;
    step();
    cfg_valid = 1'b0;
    start = 1'b1; burst_len = BURSTW'(2);
    step();
    start = 1'b0;
    k = 0;
    while (k < 24 || exp_nc(k, 2)) begin
      step(); k++;
      checks++;
      if ({busy, newclk, tick, done} !== exp_run(k, 2)) begin
        errors++; $display("FAIL burst_ignored k=%0d got %b exp %b", k, {busy, newclk, tick, done}, exp_run(k, 2));
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0; burst_len = '0;
    checks++;
    if ({busy, newclk, tick, done} !== 4'b0001) begin
      errors++; $display("FAIL burst_ignored_stop got %b exp 0001", {busy, newclk, tick, done});
    end
    step();
  endtask
`endif

  task automatic test_reset_mid();
    int k;
    cfg_valid = 1'b1; cfg_half = 32'd4;
    step();
    cfg_valid = 1'b0;
    start = 1'b1; burst_len = BURSTW'(3);
    step();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) step();
    cfg_valid = 1'b1; cfg_half = 32'd2;
    step();
    cfg_valid = 1'b0;
    checks++;
    if ({busy, newclk, tick, done, cfg_ready} !== 5'b11000) begin
      errors++; $display("FAIL mid_pending got %b exp 11000", {busy, newclk, tick, done, cfg_ready});
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, newclk, tick, done, cfg_ready} !== 5'b00001 || cur_half !== 32'(DEFAULT_HALF)) begin
      errors++; $display("FAIL mid_async_reset got %b half %0d exp 00001 half %0d",
                         {busy, newclk, tick, done, cfg_ready}, cur_half, DEFAULT_HALF);
    end
    #2 reset_n = 1'b1;
    burst_len = '0;
    step();
    checks++;
    if ({busy, newclk, tick, done, cfg_ready} !== 5'b00001 || cur_half !== 32'(DEFAULT_HALF)) begin
      errors++; $display("FAIL mid_after_reset got %b half %0d exp 00001 half %0d",
                         {busy, newclk, tick, done, cfg_ready}, cur_half, DEFAULT_HALF);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (k < 12 || exp_nc(k, DEFAULT_HALF)) begin
      step(); k++;
      checks++;
      if ({busy, newclk, tick, done} !== exp_run(k, DEFAULT_HALF) || cur_half !== 32'(DEFAULT_HALF)) begin
        errors++; $display("FAIL mid_rerun k=%0d got %b half %0d exp %b half %0d", k,
                           {busy, newclk, tick, done}, cur_half, exp_run(k, DEFAULT_HALF), DEFAULT_HALF);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if ({busy, newclk, tick, done} !== 4'b0001) begin
      errors++; $display("FAIL mid_stop got %b exp 0001", {busy, newclk, tick, done});
    end
    step();
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_cfg_in_run();
    test_stop_drain();
    test_idle_controls();
    test_cfg_zero();
    test_burst();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
